wide_alu_result_streamer: RTL and testbench

Downstream consumer of the wide ALU. It detects each completed operation from the ALU status and result outputs and captures the wide result into a shadow register. It then streams that result as narrow beats, LSB first, over a valid/ready interface toward the bus/DMA side. This lets the ALU start the next operation while the previous result drains.

---
 rtl/wide_alu_result_streamer.sv | 121 ++++++++++++
 tb/tb_wide_alu_result_streamer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_alu_result_streamer.sv
// Captures each completed wide-ALU result into a shadow register and drains it
// as LSB-first beats over valid/ready, so the ALU can start its next operation.
package wide_alu_pkg;
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PENDING        = 2'd1,
        ERROR_OPCODE   = 2'd2,
        ERROR_OVERFLOW = 2'd3
    } status_e;
endpackage

module wide_alu_result_streamer #(
    parameter int RESULT_WIDTH = 512,
    parameter int BEAT_WIDTH   = 32,
    parameter int TAG_WIDTH    = 8,
    localparam int NUM_BEATS   = RESULT_WIDTH / BEAT_WIDTH,
    localparam int IDX_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  wide_alu_pkg::status_e   alu_status_i,
    input  logic [RESULT_WIDTH-1:0] alu_result_i,
    output logic [BEAT_WIDTH-1:0]   beat_data_o,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic                    beat_last_o,
    output logic [IDX_W-1:0]        beat_idx_o,
    output logic [TAG_WIDTH-1:0]    beat_tag_o,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic [TAG_WIDTH-1:0]    drop_cnt_o,
    input  logic                    clear_overrun_i
);

    typedef enum logic {S_IDLE, S_STREAM} state_e;

    function automatic logic [TAG_WIDTH-1:0] sat_inc(input logic [TAG_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e                                r_state;
    state_e                                w_state_nxt;
    wide_alu_pkg::status_e                 r_prev_status;
    logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]  r_shadow;
    logic [IDX_W-1:0]                      r_idx;
    logic [TAG_WIDTH-1:0]                  r_tag;
    logic [TAG_WIDTH-1:0]                  r_next_tag;
    logic                                  r_overrun;
    logic [TAG_WIDTH-1:0]                  r_drop_cnt;

    logic w_complete;
    logic w_xfer;
    logic w_last;
    logic w_cap_ok;
    logic w_capture;
    logic w_drop;

    assign w_complete = (r_prev_status == wide_alu_pkg::PENDING) &&
                        (alu_status_i == wide_alu_pkg::IDLE);
    assign w_xfer     = (r_state == S_STREAM) && beat_ready_i;
    assign w_last     = (r_idx == IDX_W'(NUM_BEATS - 1));
    // The final beat leaving this cycle frees the shadow for a back-to-back capture.
    assign w_cap_ok   = (r_state == S_IDLE) || (w_xfer && w_last);
    assign w_capture  = w_complete && w_cap_ok;
    assign w_drop     = w_complete && !w_cap_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_capture) w_state_nxt = S_STREAM;
            S_STREAM: if (w_xfer && w_last && !w_capture) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_prev_status <= wide_alu_pkg::IDLE;
            r_shadow      <= '0;
            r_idx         <= '0;
            r_tag         <= '0;
            r_next_tag    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_status <= alu_status_i;
            if (w_capture) begin
                r_shadow   <= alu_result_i;
                r_tag      <= r_next_tag;
                r_next_tag <= r_next_tag + 1'b1;
                r_idx      <= '0;
            end else if (w_xfer) begin
                r_idx      <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun  <= 1'b1;
            r_drop_cnt <= sat_inc(clear_overrun_i ? '0 : r_drop_cnt);
        end else if (clear_overrun_i) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign beat_valid_o = (r_state == S_STREAM);
    assign busy_o       = (r_state == S_STREAM);
    assign beat_last_o  = (r_state == S_STREAM) && w_last;
    assign beat_data_o  = (r_state == S_STREAM) ? r_shadow[r_idx] : '0;
    assign beat_idx_o   = r_idx;
    assign beat_tag_o   = r_tag;
    assign overrun_o    = r_overrun;
    assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_wide_alu_result_streamer.sv
// Directed bench for wide_alu_result_streamer: expected beats are queued when a
// completion is driven and checked as each beat handshakes.
module tb_wide_alu_result_streamer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
        logic [7:0]  tag;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    wide_alu_pkg::status_e status = wide_alu_pkg::IDLE;
    logic [511:0]          result = '0;
    logic                  ready = 1'b0;
    logic                  clear = 1'b0;
    logic [31:0]           data;
    logic                  valid;
    logic                  last;
    logic [3:0]            idx;
    logic [7:0]            tag;
    logic                  busy;
    logic                  overrun;
    logic [7:0]            drop_cnt;

    int    total = 0;
    int    bad = 0;
    beat_t sb[$];
    logic  hold_pending = 1'b0;
    beat_t hold;

    wide_alu_result_streamer dut (
        .clk_i(clk), .rst_i(rst), .alu_status_i(status), .alu_result_i(result),
        .beat_data_o(data), .beat_valid_o(valid), .beat_ready_i(ready),
        .beat_last_o(last), .beat_idx_o(idx), .beat_tag_o(tag), .busy_o(busy),
        .overrun_o(overrun), .drop_cnt_o(drop_cnt), .clear_overrun_i(clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_result(input logic [511:0] r, input logic [7:0] t);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.data = r[k*32 +: 32];
            b.idx  = 4'(k);
            b.last = (k == 15);
            b.tag  = t;
            sb.push_back(b);
        end
    endtask

    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (hold_pending) begin
            chk("stall_data", data, hold.data);
            chk("stall_idx", idx, hold.idx);
            chk("stall_last", last, hold.last);
            chk("stall_tag", tag, hold.tag);
        end
        if (valid && ready) begin
            if (sb.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("beat_data", data, e.data);
                chk("beat_idx", idx, e.idx);
                chk("beat_last", last, e.last);
                chk("beat_tag", tag, e.tag);
            end
        end
        hold_pending = valid && !ready;
        hold = '{data: data, idx: idx, last: last, tag: tag};
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input logic [511:0] r);
        status = wide_alu_pkg::PENDING;
        tick();
        status = wide_alu_pkg::IDLE;
        result = r;
        tick();
    endtask

    task automatic drain(input bit toggle);
        int n = 0;
        while (busy && n < 400) begin
            if (toggle) ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        chk("drain_timeout", busy, 0);
        chk("sb_empty", sb.size(), 0);
        ready = 1'b1;
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int n = 0;
        while (idx != target && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idx", idx, target);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_valid"}, valid, 0);
        chk({pfx, "_last"}, last, 0);
        chk({pfx, "_idx"}, idx, 0);
        chk({pfx, "_data"}, data, 0);
        chk({pfx, "_tag"}, tag, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_overrun"}, overrun, 0);
        chk({pfx, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        logic [511:0] r1, r2, r3;
        for (int k = 0; k < 16; k++) begin
            r1[k*32 +: 32] = 32'h1000_0000 + k;
            r2[k*32 +: 32] = 32'h2000_0000 + k;
            r3[k*32 +: 32] = 32'h3000_0000 + k;
        end

        // Reset state
        #12;
        chk_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Single result, ready held high
        ready = 1'b1;
        push_result(r1, 8'd0);
        complete(r1);
        chk("t1_valid_latency", valid, 1);
        chk("t1_idx0", idx, 0);
        drain(1'b0);
        chk("t1_busy_end", busy, 0);

        // Same result, ready pattern 1,0,0,1
        push_result(r1, 8'd1);
        complete(r1);
        chk("t2_valid", valid, 1);
        drain(1'b1);

        // Completion while beat 5 is stalled is dropped
        push_result(r1, 8'd2);
        complete(r1);
        wait_idx(4'd5);
        ready = 1'b0;
        complete({16{32'hFFFF_FFFF}});
        chk("t3_overrun", overrun, 1);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_idx_held", idx, 5);
        chk("t3_tag_held", tag, 2);
        ready = 1'b1;
        drain(1'b0);

        // Completion coinciding with the last handshake
        push_result(r1, 8'd3);
        complete(r1);
        wait_idx(4'd14);
        status = wide_alu_pkg::PENDING;
        tick();
        chk("t4_last_pending", last, 1);
        status = wide_alu_pkg::IDLE;
        result = r2;
        push_result(r2, 8'd4);
        tick();
        chk("t4_valid_kept", valid, 1);
        chk("t4_idx", idx, 0);
        chk("t4_tag", tag, 4);
        chk("t4_data", data, 32'h2000_0000);
        drain(1'b0);

        // Error path is not a completion
        status = wide_alu_pkg::PENDING;
        tick();
        status = wide_alu_pkg::ERROR_OPCODE;
        tick();
        status = wide_alu_pkg::IDLE;
        tick();
        tick();
        chk("t5_err_valid", valid, 0);
        chk("t5_err_drop", drop_cnt, 1);

        // Saturating drop counter while a stream is stalled
        ready = 1'b0;
        push_result(r3, 8'd5);
        complete(r3);
        for (int i = 0; i < 300; i++) complete(r1);
        chk("t5_sat_drop", drop_cnt, 8'hFF);
        chk("t5_sat_overrun", overrun, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clr_overrun", overrun, 0);
        chk("t5_clr_drop", drop_cnt, 0);
        status = wide_alu_pkg::PENDING;
        tick();
        status = wide_alu_pkg::IDLE;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clr_vs_drop_ovr", overrun, 1);
        chk("t5_clr_vs_drop_cnt", drop_cnt, 1);
        ready = 1'b1;
        drain(1'b0);

        // Asynchronous reset mid-stream, then a fresh result
        push_result(r1, 8'd6);
        complete(r1);
        wait_idx(4'd7);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        sb.delete();
        hold_pending = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        push_result(r2, 8'd0);
        complete(r2);
        chk("t6_idx", idx, 0);
        chk("t6_tag", tag, 0);
        chk("t6_data", data, 32'h2000_0000);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
